uart_bcd_receiver: RTL and testbench
====================================

// Module: uart_bcd_receiver
// PURPOSE
//  Receive end of the two-digit BCD serial link. Samples an 8N1 asynchronous line and decodes ASCII digits.
//  Pairs the digits (tens first, then units) and presents them as bcd1/bcd0 with a one-cycle valid strobe.
//  Sits opposite the uart BCD transmitter; drives the display/consumer logic on the far side of the wire.
// PARAMETERS
//  CLKS_PER_BIT  16  clock cycles per serial bit; must be even and >= 4 (16 keeps sim short)
//  SYNC_STAGES   2   flops in the rx_in synchroniser; >= 2
// PORTS
//  clk        in   1  system clock; all logic on rising edge
//  rst        in   1  asynchronous, active-high reset
//  rx_in      in   1  serial line; idle high; async to clk
//  bcd0       out  4  units digit of the last complete pair
//  bcd1       out  4  tens digit of the last complete pair
//  bcd_valid  out  1  one-cycle pulse; bcd0/bcd1 were updated this cycle
//  frame_err  out  1  one-cycle pulse; stop bit sampled low
//  digit_err  out  1  one-cycle pulse; byte received OK but not in 0x30..0x39
// BEHAVIOUR
//  Reset: bcd0=bcd1=0, bcd_valid=frame_err=digit_err=0, sync flops=1, state IDLE, have_tens=0.
//  Reset asserted mid-byte aborts the byte; no pulse is generated for it.
//  Frame: 1 start(0), 8 data LSB first, 1 stop(1). All decisions use the synchronised line rxs.
//  FSM (bit counter cnt counts 0..CLKS_PER_BIT-1; bit index idx counts 0..7):
//   IDLE:  rxs==0 -> START, cnt=0.
//   START: at cnt==CLKS_PER_BIT/2-1, sample. rxs==0 -> DATA, cnt=0, idx=0.
//          rxs==1 (glitch) -> IDLE; no pulse, pairing unchanged.
//   DATA:  at cnt==CLKS_PER_BIT-1 (mid-bit), shift rxs into shreg[7] (right shift).
//          idx==7 -> STOP; otherwise idx+1.
//   STOP:  at cnt==CLKS_PER_BIT-1, sample. rxs==1 -> byte_done, go to IDLE.
//          rxs==0 -> frame_err pulse, have_tens=0, go to WAIT_HIGH.
//   WAIT_HIGH: stay until rxs==1, then IDLE. This prevents a break condition from retriggering.
//  Pairing on byte_done (same cycle as the stop sample; outputs registered, so visible next cycle):
//   byte in 0x30..0x39, have_tens==0 -> tens_reg=byte[3:0], have_tens=1.
//   byte in 0x30..0x39, have_tens==1 -> bcd1=tens_reg, bcd0=byte[3:0], bcd_valid=1, have_tens=0.
//   any other byte -> digit_err=1, have_tens=0; bcd0/bcd1 hold.
//  bcd0/bcd1 change only together, only with bcd_valid; they hold between pairs.
//  Latency: bcd_valid rises 1 clk after the mid-stop-bit sample of the units byte.
//  Pulses are mutually exclusive; at most one of the three fires per byte.
//  Back-to-back frames (next start immediately after stop) must be accepted. IDLE is re-entered at
//  mid-stop-bit, leaving half a bit of margin.
// STRUCTURE
//  Shared package/include uart_pkg: rx FSM state encoding (IDLE, START, DATA, STOP, WAIT_HIGH),
//  ASCII_ZERO=8'h30, ASCII_NINE=8'h39.
//  One sub-module: uart_rx_byte (synchroniser + bit FSM; outputs byte, byte_done, frame_err).
//  Top holds the pairing logic and output registers.
// TESTING  (CLKS_PER_BIT=16, clk period 2 ns -> 32 ns per bit; bench drives rx_in from a bit-bang task
//  or the transmitter)
//  1 Reset: rst=1 for 100 ns with rx_in=1 -> bcd0=bcd1=0, no pulses; assert rst mid-byte -> byte dropped.
//  2 Send 0x32,0x30 -> exactly one bcd_valid, with bcd1=2, bcd0=0; no pulse after the first byte.
//  3 Back-to-back 0x31,0x31,0x30,0x34 -> two bcd_valid pulses: (1,1) then (0,4).
//  4 Glitch: rx_in low for 4 clks, then high -> no pulses, state IDLE; a following pair decodes correctly.
//  5 Stop bit forced 0 on 0x35, line held low 40 clks, then 0x33,0x37 -> one frame_err; then bcd1=3, bcd0=7.
//  6 Send 0x39,0x41('A'),0x35,0x36 -> digit_err on 'A'; the 9 is discarded; then bcd1=5, bcd0=6.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings for the serial BCD link: rx FSM states and the ASCII digit range.
// Pure definitions; no logic, no latency, no backpressure.
package uart_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;

    function automatic logic is_ascii_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchroniser plus bit FSM; byte_done/frame_err strobe at the mid-stop-bit sample.
// No backpressure: every completed frame is reported exactly once, the consumer must keep up.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [2:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             shreg_q, shreg_d;
    logic                   rxs;

    assign rxs     = sync_q[SYNC_STAGES-1];
    assign rx_byte = shreg_q;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], rx_in};
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        byte_done = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = ST_START;
            end
            ST_START: begin
                // Half-bit delay re-centres all later samples on the middle of each bit.
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rxs, shreg_q[7:1]};
                    if (idx_q == 3'd7) state_d = ST_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        byte_done = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low (break) line must not be mistaken for a stream of start bits.
                cnt_d = '0;
                if (rxs) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shreg_q <= 8'd0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/uart_bcd_receiver.sv
// Pairs received ASCII digits (tens then units) into bcd1/bcd0; strobes appear 1 clk after the stop sample.
// No backpressure: bcd_valid/frame_err/digit_err are single-cycle pulses the consumer must capture.
module uart_bcd_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [3:0] bcd0,
    output logic [3:0] bcd1,
    output logic       bcd_valid,
    output logic       frame_err,
    output logic       digit_err
);

    logic [7:0] rx_byte;
    logic       rx_byte_done;
    logic       rx_frame_err;

    logic       have_tens_q, have_tens_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] bcd0_q, bcd0_d;
    logic [3:0] bcd1_q, bcd1_d;
    logic       bcd_valid_q, bcd_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       digit_err_q, digit_err_d;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx_in    (rx_in),
        .rx_byte  (rx_byte),
        .byte_done(rx_byte_done),
        .frame_err(rx_frame_err)
    );

    always_comb begin
        have_tens_d = have_tens_q;
        tens_d      = tens_q;
        bcd0_d      = bcd0_q;
        bcd1_d      = bcd1_q;
        bcd_valid_d = 1'b0;
        frame_err_d = rx_frame_err;
        digit_err_d = 1'b0;
        if (rx_frame_err) begin
            have_tens_d = 1'b0;
        end else if (rx_byte_done) begin
            if (!is_ascii_digit(rx_byte)) begin
                // Any junk byte breaks the pairing so a stale tens digit is never reused.
                digit_err_d = 1'b1;
                have_tens_d = 1'b0;
            end else if (!have_tens_q) begin
                tens_d      = rx_byte[3:0];
                have_tens_d = 1'b1;
            end else begin
                bcd1_d      = tens_q;
                bcd0_d      = rx_byte[3:0];
                bcd_valid_d = 1'b1;
                have_tens_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            have_tens_q <= 1'b0;
            tens_q      <= 4'd0;
            bcd0_q      <= 4'd0;
            bcd1_q      <= 4'd0;
            bcd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            digit_err_q <= 1'b0;
        end else begin
            have_tens_q <= have_tens_d;
            tens_q      <= tens_d;
            bcd0_q      <= bcd0_d;
            bcd1_q      <= bcd1_d;
            bcd_valid_q <= bcd_valid_d;
            frame_err_q <= frame_err_d;
            digit_err_q <= digit_err_d;
        end
    end

    assign bcd0      = bcd0_q;
    assign bcd1      = bcd1_q;
    assign bcd_valid = bcd_valid_q;
    assign frame_err = frame_err_q;
    assign digit_err = digit_err_q;

endmodule

// File: tb/tb_uart_bcd_receiver.sv
// Bench for uart_bcd_receiver: bit-banged frames, digit-pairing reference model, pulse scoreboard.
module tb_uart_bcd_receiver;

    localparam int CPB = 16;
    localparam int EV_VALID = 0;
    localparam int EV_FRAME = 1;
    localparam int EV_DIGIT = 2;

    typedef struct {
        int         kind;
        logic [3:0] b1;
        logic [3:0] b0;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [3:0] bcd0, bcd1;
    logic       bcd_valid, frame_err, digit_err;

    int   compared = 0;
    int   mismatched = 0;
    ev_t  sb[$];
    logic m_have = 1'b0;
    int   m_tens = 0;
    logic [3:0] last_b1 = 4'd0;
    logic [3:0] last_b0 = 4'd0;
    logic stim_done = 1'b0;

    uart_bcd_receiver #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_in    (rx_in),
        .bcd0     (bcd0),
        .bcd1     (bcd1),
        .bcd_valid(bcd_valid),
        .frame_err(frame_err),
        .digit_err(digit_err)
    );

    always #1 clk = ~clk;

    // Reference model: one decision per complete frame, expressed on whole bytes.
    task automatic model_frame(input int b, input bit stop_ok);
        ev_t e;
        e.b1 = 4'd0;
        e.b0 = 4'd0;
        if (!stop_ok) begin
            e.kind = EV_FRAME;
            sb.push_back(e);
            m_have = 1'b0;
        end else if (b >= 48 && b <= 57) begin
            if (!m_have) begin
                m_tens = b - 48;
                m_have = 1'b1;
            end else begin
                e.kind = EV_VALID;
                e.b1 = 4'(m_tens);
                e.b0 = 4'(b - 48);
                sb.push_back(e);
                m_have = 1'b0;
            end
        end else begin
            e.kind = EV_DIGIT;
            sb.push_back(e);
            m_have = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int low_extra, input int gap);
        model_frame(int'(b), stop_ok);
        @(negedge clk) rx_in = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) rx_in = b[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk) rx_in = stop_ok ? 1'b1 : 1'b0;
        repeat (CPB - 1 + (stop_ok ? 0 : low_extra)) @(negedge clk);
        if (gap > 0) begin
            @(negedge clk) rx_in = 1'b1;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        @(negedge clk) rx_in = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) rx_in = b[i];
            repeat (CPB - 1) @(negedge clk);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_reset(input int clks);
        @(negedge clk) rst = 1'b1;
        rx_in = 1'b1;
        m_have = 1'b0;
        last_b1 = 4'd0;
        last_b0 = 4'd0;
        repeat (clks) @(negedge clk);
        check("reset_state", {23'd0, bcd1, bcd0, bcd_valid, frame_err, digit_err}, 32'd0);
        rst = 1'b0;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic monitor();
        ev_t e;
        int n;
        logic [3:0] eb1, eb0;
        int kind;
        forever begin
            @(negedge clk);
            if (!rst) begin
                n = int'(bcd_valid) + int'(frame_err) + int'(digit_err);
                if (n > 1) begin
                    compared++;
                    mismatched++;
                    $display("FAIL pulse_exclusive: got v=%0b f=%0b d=%0b expected at most one",
                             bcd_valid, frame_err, digit_err);
                end else if (n == 1) begin
                    kind = bcd_valid ? EV_VALID : (frame_err ? EV_FRAME : EV_DIGIT);
                    compared++;
                    if (sb.size() == 0) begin
                        mismatched++;
                        $display("FAIL unexpected_pulse: got kind %0d expected none", kind);
                    end else begin
                        e = sb.pop_front();
                        eb1 = (e.kind == EV_VALID) ? e.b1 : last_b1;
                        eb0 = (e.kind == EV_VALID) ? e.b0 : last_b0;
                        if (kind != e.kind || bcd1 !== eb1 || bcd0 !== eb0) begin
                            mismatched++;
                            $display("FAIL pulse_event: got kind %0d bcd1=%0d bcd0=%0d expected kind %0d bcd1=%0d bcd0=%0d",
                                     kind, bcd1, bcd0, e.kind, eb1, eb0);
                        end
                        if (e.kind == EV_VALID) begin
                            last_b1 = e.b1;
                            last_b0 = e.b0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic stimulus();
        logic [7:0] b;
        bit ok;
        int wait_clks;
        // Power-on reset with the line idle.
        rst = 1'b1;
        rx_in = 1'b1;
        #100;
        apply_reset(4);

        // Tens then units.
        send_frame(8'h32, 1, 0, CPB);
        send_frame(8'h30, 1, 0, CPB);

        // Reset in the middle of a units byte drops that byte and the pending tens.
        send_frame(8'h35, 1, 0, CPB);
        send_partial(8'h36, 4);
        apply_reset(10);
        send_frame(8'h37, 1, 0, 0);
        send_frame(8'h38, 1, 0, CPB);

        // Back-to-back frames.
        send_frame(8'h31, 1, 0, 0);
        send_frame(8'h31, 1, 0, 0);
        send_frame(8'h30, 1, 0, 0);
        send_frame(8'h34, 1, 0, CPB);

        // Short low glitch, then a valid pair.
        @(negedge clk) rx_in = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk) rx_in = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send_frame(8'h38, 1, 0, 0);
        send_frame(8'h39, 1, 0, CPB);

        // Stop bit low with the line held low, then recovery.
        send_frame(8'h35, 0, 40 - CPB, 2 * CPB);
        send_frame(8'h33, 1, 0, 0);
        send_frame(8'h37, 1, 0, CPB);

        // Non-digit breaks a pending tens.
        send_frame(8'h39, 1, 0, 0);
        send_frame(8'h41, 1, 0, 0);
        send_frame(8'h35, 1, 0, 0);
        send_frame(8'h36, 1, 0, CPB);

        // Randomised traffic.
        for (int k = 0; k < 48; k++) begin
            if ($urandom_range(0, 9) < 7) b = 8'(8'h30 + $urandom_range(0, 9));
            else                          b = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 9) != 0);
            if (ok) send_frame(b, 1, 0, int'($urandom_range(0, 24)));
            else    send_frame(b, 0, int'($urandom_range(0, 30)), int'($urandom_range(CPB, 2 * CPB)));
        end

        rx_in = 1'b1;
        wait_clks = 0;
        while (sb.size() != 0 && wait_clks < 400) begin
            @(negedge clk);
            wait_clks++;
        end
        repeat (4 * CPB) @(negedge clk);
        check("drain_pending", 32'(sb.size()), 32'd0);
        check("final_bcd", {24'd0, bcd1, bcd0}, {24'd0, last_b1, last_b0});
        stim_done = 1'b1;
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join_any
        disable fork;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #400000;
        if (!stim_done) begin
            $display("FAIL timeout: got no completion expected stimulus to finish");
            $fatal(1, "timeout");
        end
    end

endmodule
